// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB encodings shared by the FreeAHB master side and the SRAM
// responder, plus the responder's state type and a byte-lane helper.
//   htrans_e      : IDLE / BUSY / NONSEQ / SEQ
//   hresp_e       : OKAY / ERROR / RETRY / SPLIT (responder only uses OKAY, ERROR)
//   hsize_e       : BYTE / HALF / WORD
//   slave_state_e : responder FSM states
//   lane_enable() : byte-lane mask for a little-endian access of a given size
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slave_state_e;

    // size is the low two bits of HSIZE; only legal (already aligned) accesses reach here.
    function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            2'd0:    be = 4'b0001 << addr_lo;
            2'd1:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_sram_bytemem.sv
// ahb_sram_bytemem: DEPTH x 32-bit storage with a byte-enabled synchronous
// write port and an asynchronous read port. Contents are not reset.
//   clk_i    : clock
//   we_i     : write strobe
//   be_i     : byte-lane enables, bit n covers wdata_i[8n+7:8n]
//   waddr_i  : word write address
//   wdata_i  : write data
//   raddr_i  : word read address
//   rdata_o  : read data (combinational)
module ahb_sram_bytemem #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB responder backed by a word-addressed SRAM, with a
// programmable number of wait states per transfer and a two-cycle ERROR
// response for out-of-range, misaligned or oversized accesses.
//   i_hclk, i_hreset_n       : clock, synchronous active-low reset
//   i_hsel, i_haddr, i_htrans: address phase select / address / transfer type
//   i_hwrite, i_hsize        : direction and access size
//   i_hburst                 : ignored, every beat is decoded on its own
//   i_hwdata                 : write data (data phase)
//   i_hready                 : bus HREADY, gates address phase sampling
//   o_hreadyout, o_hresp     : ready and OKAY/ERROR response
//   o_hrdata                 : read data, zero outside legal read data phases
//
// state | meaning
// IDLE  | no data phase, or completion cycle of a legal transfer (ready, OKAY)
// WAIT  | inserting wait states, counter runs down to zero (not ready)
// ERR1  | first error response cycle (not ready, ERROR)
// ERR2  | second error response cycle (ready, ERROR), new address phase allowed
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        i_hclk,
    input  logic        i_hreset_n,
    input  logic        i_hsel,
    input  logic [31:0] i_haddr,
    input  logic [1:0]  i_htrans,
    input  logic        i_hwrite,
    input  logic [2:0]  i_hsize,
    input  logic [2:0]  i_hburst,
    input  logic [31:0] i_hwdata,
    input  logic        i_hready,
    output logic        o_hreadyout,
    output logic [1:0]  o_hresp,
    output logic [31:0] o_hrdata
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // 33 bits so DEPTH*4 never wraps against a full 32-bit address
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) * 33'd4;

    slave_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             hreadyout_q;
    hresp_e           hresp_q;
    logic             pend_q;
    logic             write_q;
    logic             err_q;
    logic [AW+1:0]    addr_q;
    logic [1:0]       size_q;

    logic        accept;
    logic        size_err;
    logic        align_err;
    logic        range_err;
    logic        req_err;
    logic        complete;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;

    wire unused_inputs = ^{i_hburst, i_htrans[0]};

    // Only cycles where we are ready can open a new data phase; otherwise the bus holds the request.
    assign accept    = i_hready & i_hsel & i_htrans[1] & hreadyout_q;
    assign size_err  = (i_hsize > 3'd2);
    assign align_err = ((i_hsize == 3'd1) & i_haddr[0])
                     | ((i_hsize == 3'd2) & (i_haddr[1:0] != 2'b00));
    assign range_err = ({1'b0, i_haddr} >= ADDR_LIMIT);
    assign req_err   = size_err | align_err | range_err;

    // A pending transfer sitting in IDLE is in its completion cycle.
    assign complete = (state_q == ST_IDLE) & pend_q & ~err_q;
    assign mem_we   = complete & write_q & i_hreset_n;
    assign mem_be   = lane_enable(size_q, addr_q[1:0]);

    always_ff @(posedge i_hclk) begin
        if (!i_hreset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            pend_q      <= 1'b0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ERR2: begin
                    if (accept) begin
                        pend_q  <= 1'b1;
                        write_q <= i_hwrite;
                        err_q   <= req_err;
                        addr_q  <= i_haddr[AW+1:0];
                        size_q  <= i_hsize[1:0];
                        if (WAIT_STATES > 0) begin
                            state_q     <= ST_WAIT;
                            cnt_q       <= CNT_LOAD;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= HRESP_OKAY;
                        end else if (req_err) begin
                            state_q     <= ST_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= HRESP_ERROR;
                        end else begin
                            state_q     <= ST_IDLE;
                            hreadyout_q <= 1'b1;
                            hresp_q     <= HRESP_OKAY;
                        end
                    end else begin
                        pend_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        if (err_q) begin
                            state_q     <= ST_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= HRESP_ERROR;
                        end else begin
                            state_q     <= ST_IDLE;
                            hreadyout_q <= 1'b1;
                            hresp_q     <= HRESP_OKAY;
                        end
                    end
                end
                ST_ERR1: begin
                    state_q     <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_ERROR;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                    pend_q      <= 1'b0;
                end
            endcase
        end
    end

    ahb_sram_bytemem #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem (
        .clk_i  (i_hclk),
        .we_i   (mem_we),
        .be_i   (mem_be),
        .waddr_i(addr_q[AW+1:2]),
        .wdata_i(i_hwdata),
        .raddr_i(addr_q[AW+1:2]),
        .rdata_o(mem_rdata)
    );

    assign o_hreadyout = hreadyout_q;
    assign o_hresp     = hresp_q;
    // Read data is combinational from the array so a read right behind a write sees the new word.
    assign o_hrdata    = (pend_q & ~write_q & ~err_q &
                          ((state_q == ST_IDLE) | (state_q == ST_WAIT))) ? mem_rdata : 32'h0;

endmodule
